// File: rtl/match_log_pkg.sv
// Shared widths and the record layout for the match event logger.
package match_log_pkg;

  localparam int IDX_W     = 8;
  localparam int DEPTH_DEF = 4;
  localparam int GAP_W_DEF = 8;
  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic [IDX_W-1:0]     idx;
    logic [GAP_W_DEF-1:0] gap;
  } match_rec_t;

endpackage

// File: rtl/mel_fifo.sv
// Record buffer for the match event logger: synchronous FIFO with flush.
// The head entry is read combinationally from the registered read pointer.
module mel_fifo
  import match_log_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = IDX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/match_event_logger.sv
// Logs rising edges of the sequence-detector flag as {index, gap} records.
// Define MATCH_LOG_GAP_EN to build the inter-event gap counter; otherwise rd_gap is 0.
module match_event_logger
  import match_log_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int GAP_W = GAP_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             match_in,
  input  logic             clear,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [IDX_W-1:0] rd_idx,
  output logic [GAP_W-1:0] rd_gap,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow
);

`ifdef MATCH_LOG_GAP_EN
  localparam int REC_W = IDX_W + GAP_W;
  logic [GAP_W-1:0] gap_cnt;
`else
  localparam int REC_W = IDX_W;
`endif

  logic             match_d;
  logic             evt;
  logic             push;
  logic             pop;
  logic             drop;
  logic             full;
  logic             empty;
  logic [IDX_W-1:0] idx_cnt;
  logic [IDX_W-1:0] idx_next;
  logic [REC_W-1:0] wdata;
  logic [REC_W-1:0] rdata;

  assign evt      = match_in & ~match_d;
  assign pop      = ~empty & rd_ready & ~clear;
  assign push     = evt & ~clear & (~full | pop);
  assign drop     = evt & ~clear & full & ~pop;
  // Index wraps on its own so it keeps moving after match_count saturates.
  assign idx_next = idx_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_d     <= 1'b0;
      match_count <= '0;
      idx_cnt     <= '0;
      overflow    <= 1'b0;
    end else begin
      match_d <= match_in;
      if (clear) begin
        match_count <= '0;
        idx_cnt     <= '0;
        overflow    <= 1'b0;
      end else begin
        if (evt) begin
          if (~&match_count) match_count <= match_count + 1'b1;
          idx_cnt <= idx_next;
        end
        if (drop) overflow <= 1'b1;
      end
    end
  end

`ifdef MATCH_LOG_GAP_EN
  // Idle at 0 until the first event, then count cycles since the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (clear) begin
      gap_cnt <= '0;
    end else if (evt) begin
      gap_cnt <= GAP_W'(1);
    end else if ((gap_cnt != '0) && ~&gap_cnt) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  assign wdata  = {idx_next, gap_cnt};
  assign rd_gap = empty ? '0 : rdata[GAP_W-1:0];
`else
  assign wdata  = idx_next;
  assign rd_gap = '0;
`endif

  assign rd_valid = ~empty;
  assign rd_idx   = empty ? '0 : rdata[REC_W-1 -: IDX_W];

  mel_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

endmodule
